// File: rtl/smg_display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : smg_display_arbiter_if
// Purpose  : Source/display bundle between number sources and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface smg_display_arbiter_if;
    logic [2:0]  Req_Sig;
    logic [11:0] Num0_Sig;
    logic [11:0] Num1_Sig;
    logic [11:0] Num2_Sig;
    logic [11:0] Number_Sig;
    logic [2:0]  Grant_Sig;
    logic        Busy_Sig;

    modport master (
        output Req_Sig, Num0_Sig, Num1_Sig, Num2_Sig,
        input  Number_Sig, Grant_Sig, Busy_Sig
    );

    modport slave (
        input  Req_Sig, Num0_Sig, Num1_Sig, Num2_Sig,
        output Number_Sig, Grant_Sig, Busy_Sig
    );
endinterface
`default_nettype wire

// File: rtl/smg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : smg_display_arbiter
// Purpose  : Round-robin, dwell-limited time sharing of one 3-digit display.
// Revision : 1.0 - initial release
// ============================================================================
module smg_display_arbiter #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    smg_display_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         ptr_q;
    logic [2:0]         grant_q;
    logic [11:0]        number_q;
    logic               busy_q;

    // First requester after ptr in the order ptr+1, ptr+2, ptr (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [1:0] o0, o1, o2;
        case (ptr)
            2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (req[o0])      rr_pick = o0;
        else if (req[o1]) rr_pick = o1;
        else              rr_pick = o2;
    endfunction

    function automatic logic [11:0] num_of(input logic [1:0] idx, input logic [11:0] n0,
                                           input logic [11:0] n1, input logic [11:0] n2);
        case (idx)
            2'd0:    num_of = n0;
            2'd1:    num_of = n1;
            default: num_of = n2;
        endcase
    endfunction

    logic [2:0]  w_req;
    logic [2:0]  w_req_other;
    logic [1:0]  w_pick_all;
    logic [1:0]  w_pick_other;
    logic [11:0] w_num_all;
    logic [11:0] w_num_other;
    logic [11:0] w_num_owner;

    assign w_req        = bus.Req_Sig;
    assign w_req_other  = w_req & ~grant_q;
    assign w_pick_all   = rr_pick(w_req, ptr_q);
    assign w_pick_other = rr_pick(w_req_other, ptr_q);
    assign w_num_all    = num_of(w_pick_all,   bus.Num0_Sig, bus.Num1_Sig, bus.Num2_Sig);
    assign w_num_other  = num_of(w_pick_other, bus.Num0_Sig, bus.Num1_Sig, bus.Num2_Sig);
    assign w_num_owner  = num_of(ptr_q,        bus.Num0_Sig, bus.Num1_Sig, bus.Num2_Sig);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= 2'd2;
            grant_q  <= 3'b000;
            number_q <= 12'h000;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req != 3'b000) begin
                        state_q  <= S_HOLD;
                        ptr_q    <= w_pick_all;
                        grant_q  <= 3'b001 << w_pick_all;
                        number_q <= w_num_all;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                default: begin
                    // Owner dropping its request overrides the dwell entirely.
                    if ((w_req & grant_q) == 3'b000) begin
                        if (w_req != 3'b000) begin
                            ptr_q    <= w_pick_all;
                            grant_q  <= 3'b001 << w_pick_all;
                            number_q <= w_num_all;
                            cnt_q    <= '0;
                        end else begin
                            state_q  <= S_IDLE;
                            grant_q  <= 3'b000;
                            busy_q   <= 1'b0;
                        end
                    end else if (cnt_q == c_DWELL_LAST && w_req_other != 3'b000) begin
                        ptr_q    <= w_pick_other;
                        grant_q  <= 3'b001 << w_pick_other;
                        number_q <= w_num_other;
                        cnt_q    <= '0;
                    end else begin
                        number_q <= w_num_owner;
                        if (cnt_q != c_DWELL_LAST) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Number_Sig = number_q;
    assign bus.Grant_Sig  = grant_q;
    assign bus.Busy_Sig   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_smg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_smg_display_arbiter
// Purpose  : Scoreboard bench for smg_display_arbiter with DWELL_CYCLES = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smg_display_arbiter;

    typedef struct {
        int          cyc;
        logic [2:0]  grant;
        logic [11:0] num;
        logic        busy;
        string       name;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;
    int   nvec = 0;
    int   nmis = 0;
    exp_t q[$];

    smg_display_arbiter_if bus ();

    smg_display_arbiter #(
        .DWELL_CYCLES (4),
        .CNT_W        (3)
    ) dut (
        .CLK  (clk),
        .RSTn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                nvec++;
                if (e.cyc != cyc || bus.Grant_Sig !== e.grant ||
                    bus.Number_Sig !== e.num || bus.Busy_Sig !== e.busy) begin
                    nmis++;
                    $display("FAIL %s (cyc %0d/%0d): grant=%b num=%h busy=%b, expected grant=%b num=%h busy=%b",
                             e.name, cyc, e.cyc, bus.Grant_Sig, bus.Number_Sig, bus.Busy_Sig,
                             e.grant, e.num, e.busy);
                end
            end
        end
    end

    task automatic drive(input logic rn, input logic [2:0] req, input logic [11:0] n0,
                         input logic [11:0] n1, input logic [11:0] n2, input logic [2:0] eg,
                         input logic [11:0] en, input logic eb, input string nm);
        exp_t e;
        @(negedge clk);
        rstn         = rn;
        bus.Req_Sig  = req;
        bus.Num0_Sig = n0;
        bus.Num1_Sig = n1;
        bus.Num2_Sig = n2;
        e.cyc = cyc + 1; e.grant = eg; e.num = en; e.busy = eb; e.name = nm;
        q.push_back(e);
    endtask

    task automatic async_reset_pulse();
        exp_t e;
        @(posedge clk);
        @(posedge clk);
        #2;
        e.cyc = cyc; e.grant = 3'b000; e.num = 12'h000; e.busy = 1'b0; e.name = "async_clear";
        q.push_back(e);
        rstn = 1'b0;
    endtask

    initial begin
        logic [11:0] nums [3];
        logic [2:0]  eg;
        nums[0] = 12'h111; nums[1] = 12'h222; nums[2] = 12'h333;
        bus.Req_Sig  = 3'b111;
        bus.Num0_Sig = 12'h111;
        bus.Num1_Sig = 12'h222;
        bus.Num2_Sig = 12'h333;

        repeat (3) drive(1'b0, 3'b111, 12'h111, 12'h222, 12'h333, 3'b000, 12'h000, 1'b0, "reset");

        // First step releases reset; each source then keeps exactly 4 cycles.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) begin
                eg = 3'b001 << (g % 3);
                drive(1'b1, 3'b111, 12'h111, 12'h222, 12'h333, eg, nums[g % 3], 1'b1, "rotate");
            end
        end

        drive(1'b1, 3'b010, 12'h111, 12'h123, 12'h333, 3'b010, 12'h123, 1'b1, "single_grant");
        repeat (10) drive(1'b1, 3'b010, 12'h111, 12'h123, 12'h333, 3'b010, 12'h123, 1'b1, "single_hold");
        drive(1'b1, 3'b010, 12'h111, 12'h456, 12'h333, 3'b010, 12'h456, 1'b1, "single_live");

        drive(1'b1, 3'b001, 12'h111, 12'h456, 12'h333, 3'b001, 12'h111, 1'b1, "early_own0");
        drive(1'b1, 3'b001, 12'h111, 12'h456, 12'h333, 3'b001, 12'h111, 1'b1, "early_own0_hold");
        drive(1'b1, 3'b100, 12'h111, 12'h456, 12'h333, 3'b100, 12'h333, 1'b1, "early_switch");
        repeat (3) drive(1'b1, 3'b101, 12'h111, 12'h456, 12'h333, 3'b100, 12'h333, 1'b1, "early_dwell_restart");
        drive(1'b1, 3'b101, 12'h111, 12'h456, 12'h333, 3'b001, 12'h111, 1'b1, "early_dwell_expire");

        drive(1'b1, 3'b000, 12'h111, 12'h456, 12'h333, 3'b000, 12'h111, 1'b0, "idle_return");
        drive(1'b1, 3'b000, 12'h999, 12'h456, 12'h333, 3'b000, 12'h111, 1'b0, "idle_hold_num");

        drive(1'b1, 3'b100, 12'h999, 12'h456, 12'h333, 3'b100, 12'h333, 1'b1, "hold_src2");
        async_reset_pulse();
        drive(1'b1, 3'b100, 12'h999, 12'h456, 12'h333, 3'b100, 12'h333, 1'b1, "post_reset_grant");
        drive(1'b1, 3'b000, 12'h999, 12'h456, 12'h333, 3'b000, 12'h333, 1'b0, "final_idle");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smg_display_arbiter.md
Name: smg_display_arbiter

Overview:
- Time-shares the 3-digit seven-segment display driver between three independent number sources (requesters).
- Sits between the sources and the display driver; drives the driver's 12-bit Number_Sig input.
- Round-robin arbitration with a minimum dwell time, so each active source stays on the display long enough to read.
- Reports the current owner with a one-hot grant.

Parameters:
- DWELL_CYCLES, 50000000: minimum clock cycles a granted source keeps the display while others are waiting (1 s at 50 MHz); legal range 2 .. 2^26-1.
- CNT_W, 26: width of the dwell counter; must hold DWELL_CYCLES-1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RSTn  input  1  asynchronous, active-low reset.
- Req_Sig  input  3  request per source; bit i high = source i wants the display.
- Num0_Sig  input  12  number from source 0 (3 BCD digits, [11:8] hundreds).
- Num1_Sig  input  12  number from source 1.
- Num2_Sig  input  12  number from source 2.
- Number_Sig  output  12  number to the display driver.
- Grant_Sig  output  3  one-hot current owner; 000 = none.
- Busy_Sig  output  1  high while in HOLD.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low (RSTn); all registers clear immediately when RSTn goes low.
- Reset values:
  - Number_Sig = 12'h000, Grant_Sig = 3'b000, Busy_Sig = 0.
  - State = IDLE, dwell counter = 0, round-robin pointer = 2 (so source 0 wins first).
- All outputs are registered.
- Round-robin selection:
  - Search order starts at pointer+1 mod 3 and wraps.
  - The pointer is set to the index of each new grant.
- State IDLE:
  - Grant_Sig = 000, Busy_Sig = 0, Number_Sig holds its last value.
  - On an edge where Req_Sig != 0: select the winner, set Grant_Sig one-hot, load Number_Sig from the winner's NumX_Sig, clear the counter, go to HOLD.
  - Latency: request sampled at edge k, grant and number visible after edge k.
- State HOLD:
  - Busy_Sig = 1.
  - Number_Sig follows the granted source's NumX_Sig live, registered, 1-cycle latency.
  - Counter increments by 1 each cycle and saturates at DWELL_CYCLES-1.
- Release from HOLD, in priority order:
  1. Granted Req bit low → release immediately, regardless of the counter. If another Req bit is high on the same edge, grant it directly (round-robin from the current pointer), clear the counter, stay in HOLD. Otherwise go to IDLE with Grant_Sig = 000.
  2. Counter == DWELL_CYCLES-1 and another Req bit is high → switch to the next requester in round-robin order, load its number, clear the counter.
  3. Counter == DWELL_CYCLES-1 and only the owner requests → keep the grant; counter stays saturated. Switching then happens on the first edge another request appears.
- Never more than one Grant_Sig bit high; Grant_Sig never changes except on the transitions above.
- Requests that arrive and drop while another source holds the display before dwell expiry are lost; no queuing.
- Simultaneous requests from IDLE: round-robin order decides.
  - Example: after reset, Req_Sig = 111 grants source 0, then 1, then 2, then 0.
- Reset mid-HOLD: outputs return to their reset values at once. After release, the first request is arbitrated as after power-up.
- Number_Sig is passed through unmodified (no BCD validation).

Test Plan (DWELL_CYCLES = 4):
- Reset: RSTn low for 3 cycles with Req_Sig = 111 → Number_Sig = 000, Grant_Sig = 000, Busy_Sig = 0 throughout; RSTn high → source 0 is granted on the first edge.
- Single requester: Req_Sig = 010, Num1_Sig = 12'h123 → Grant_Sig = 010 and Number_Sig = 123 one edge later. Hold for 10 cycles → grant unchanged. Num1_Sig changes to 12'h456 → Number_Sig = 456 one cycle later.
- Rotation: Req_Sig = 111, Num0/1/2 = 111/222/333 → grants 001, 010, 100, 001 each held exactly 4 cycles; Number_Sig tracks 111, 222, 333, 111.
- Early release: source 0 granted, Req_Sig changes to 100 after 2 cycles → Grant_Sig = 100 on the next edge (no dwell wait); counter restarts.
- Idle return: owner drops with no other request → Grant_Sig = 000, Busy_Sig = 0; Number_Sig keeps its last value.
- Async reset mid-HOLD: RSTn pulsed low between clock edges → outputs clear before the next edge; after release, Req_Sig = 100 is granted source 2 on the first edge.
